// File: rtl/router_mem_pkg.sv
// Shared defaults and helpers for the router memory arbiter.
package router_mem_pkg;

  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefWidth = 32;

  // Address width for a given depth; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer.
// The pointer moves to one past the winner; it holds when nothing is granted.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW:0]   sum;
  logic [PtrW-1:0] idx;
  logic            found;

  // Circular priority search starting at ptr_q; grants are forced low in reset.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // sum < 2*NREQ, so one conditional subtract is enough to wrap.
      sum = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (sum >= (PtrW+1)'(NREQ)) begin
        sum = sum - (PtrW+1)'(NREQ);
      end
      idx = sum[PtrW-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = (idx == PtrW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
    end
    if (rst_i) begin
      gnt_o = '0;
      ptr_d = ptr_q;
    end
  end

  // Pointer state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/router_mem_arb.sv
// Shares one write/one read memory among NREQ requesters. Write and read
// ports are arbitrated independently; read data returns one cycle after grant.
module router_mem_arb
  import router_mem_pkg::*;
#(
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned WIDTH = DefWidth,
  localparam int unsigned AWIDTH = addr_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        wr_req,
  input  logic [NREQ*AWIDTH-1:0] wr_addr,
  input  logic [NREQ*WIDTH-1:0]  wr_data,
  output logic [NREQ-1:0]        wr_gnt,
  input  logic [NREQ-1:0]        rd_req,
  input  logic [NREQ*AWIDTH-1:0] rd_addr,
  output logic [NREQ-1:0]        rd_gnt,
  output logic [NREQ-1:0]        rd_vld,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   mem_wr_en,
  output logic [AWIDTH-1:0]      mem_wr_addr,
  output logic [WIDTH-1:0]       mem_wr_data,
  output logic                   mem_rd_en,
  output logic [AWIDTH-1:0]      mem_rd_addr,
  input  logic [WIDTH-1:0]       mem_rd_data
);

  logic [NREQ-1:0] rd_pend_q;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_wr_arb (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (wr_req),
    .gnt_o (wr_gnt)
  );

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rd_arb (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (rd_req),
    .gnt_o (rd_gnt)
  );

  // Write-port mux from the one-hot winner; zeros when idle.
  always_comb begin
    mem_wr_en   = |wr_gnt;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (wr_gnt[i]) begin
        mem_wr_addr = wr_addr[i*AWIDTH +: AWIDTH];
        mem_wr_data = wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Read-port mux from the one-hot winner; zeros when idle.
  always_comb begin
    mem_rd_en   = |rd_gnt;
    mem_rd_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rd_gnt[i]) begin
        mem_rd_addr = rd_addr[i*AWIDTH +: AWIDTH];
      end
    end
  end

  // Track which requester owns the read data arriving next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= '0;
    end else begin
      rd_pend_q <= rd_gnt;
    end
  end

  assign rd_vld  = rd_pend_q;
  assign rd_data = mem_rd_data;

endmodule

// File: tb/tb_router_mem_arb.sv
// Directed bench for router_mem_arb with a behavioural registered memory and
// a scoreboard of expected read returns.
module tb_router_mem_arb;

  localparam int NREQ   = 4;
  localparam int DEPTH  = 8;
  localparam int WIDTH  = 32;
  localparam int AWIDTH = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        wr_req;
  logic [NREQ*AWIDTH-1:0] wr_addr;
  logic [NREQ*WIDTH-1:0]  wr_data;
  logic [NREQ-1:0]        wr_gnt;
  logic [NREQ-1:0]        rd_req;
  logic [NREQ*AWIDTH-1:0] rd_addr;
  logic [NREQ-1:0]        rd_gnt;
  logic [NREQ-1:0]        rd_vld;
  logic [WIDTH-1:0]       rd_data;
  logic                   mem_wr_en;
  logic [AWIDTH-1:0]      mem_wr_addr;
  logic [WIDTH-1:0]       mem_wr_data;
  logic                   mem_rd_en;
  logic [AWIDTH-1:0]      mem_rd_addr;
  logic [WIDTH-1:0]       mem_rd_data = '0;

  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  typedef struct {
    logic [NREQ-1:0]  vld;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  router_mem_arb #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_vld      (rd_vld),
    .rd_data     (rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Registered memory, read-before-write on address collision.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input int i, input logic [AWIDTH-1:0] a, input logic [WIDTH-1:0] d);
    wr_addr[i*AWIDTH +: AWIDTH] = a;
    wr_data[i*WIDTH +: WIDTH]   = d;
  endtask

  task automatic set_rd(input int i, input logic [AWIDTH-1:0] a);
    rd_addr[i*AWIDTH +: AWIDTH] = a;
  endtask

  task automatic rd_exp(input logic [NREQ-1:0] v, input logic [WIDTH-1:0] d);
    exp_t e;
    e.vld  = v;
    e.data = d;
    sb.push_back(e);
  endtask

  // Advance one clock; check the read return owed for the previous cycle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_vld", 32'(rd_vld), 32'(e.vld));
      chk("rd_data", rd_data, e.data);
    end else begin
      chk("rd_vld_idle", 32'(rd_vld), 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    wr_req  = '0;
    rd_req  = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;

    // Requests during reset must not be granted.
    #1;
    wr_req = 4'hF;
    rd_req = 4'hF;
    #1;
    chk("rst_wr_gnt", 32'(wr_gnt), 32'h0);
    chk("rst_rd_gnt", 32'(rd_gnt), 32'h0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'h0);
    tick();
    tick();
    wr_req = '0;
    rd_req = '0;
    rst    = 1'b0;
    #1;
    chk("idle_mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("idle_mem_rd_en", 32'(mem_rd_en), 32'h0);
    chk("idle_mem_wr_addr", 32'(mem_wr_addr), 32'h0);
    chk("idle_mem_wr_data", mem_wr_data, 32'h0);
    chk("idle_mem_rd_addr", 32'(mem_rd_addr), 32'h0);
    tick();

    // All four write, held four cycles: rotation 0,1,2,3.
    for (int i = 0; i < NREQ; i++) set_wr(i, AWIDTH'(i), 32'hA0 + 32'(i));
    wr_req = 4'hF;
    for (int k = 0; k < NREQ; k++) begin
      #1;
      chk("rot_wr_gnt", 32'(wr_gnt), 32'(1) << k);
      chk("rot_mem_wr_addr", 32'(mem_wr_addr), 32'(k));
      chk("rot_mem_wr_data", mem_wr_data, 32'hA0 + 32'(k));
      tick();
    end
    wr_req = '0;

    // Single reader back-to-back: granted every cycle; read back each word.
    rd_req = 4'b0001;
    for (int k = 0; k < NREQ; k++) begin
      set_rd(0, AWIDTH'(k));
      #1;
      chk("b2b_rd_gnt", 32'(rd_gnt), 32'h1);
      chk("b2b_mem_rd_addr", 32'(mem_rd_addr), 32'(k));
      rd_exp(4'b0001, 32'hA0 + 32'(k));
      tick();
    end
    rd_req = '0;

    // Requester 2 writes addr 5, then requester 0 reads it.
    wr_req = 4'b0100;
    set_wr(2, 3'd5, 32'hDEADBEEF);
    #1;
    chk("r2_wr_gnt", 32'(wr_gnt), 32'h4);
    chk("r2_mem_wr_addr", 32'(mem_wr_addr), 32'h5);
    tick();
    wr_req = '0;
    rd_req = 4'b0001;
    set_rd(0, 3'd5);
    #1;
    chk("r0_rd_gnt", 32'(rd_gnt), 32'h1);
    rd_exp(4'b0001, 32'hDEADBEEF);
    tick();
    rd_req = '0;

    // Same-cycle write and read of addr 6: old data first, new data next.
    wr_req = 4'b0010;
    set_wr(1, 3'd6, 32'h1);
    rd_req = 4'b1000;
    set_rd(3, 3'd6);
    #1;
    chk("rbw_wr_gnt", 32'(wr_gnt), 32'h2);
    chk("rbw_rd_gnt", 32'(rd_gnt), 32'h8);
    rd_exp(4'b1000, 32'h0);
    tick();
    wr_req = '0;
    #1;
    chk("rbw2_rd_gnt", 32'(rd_gnt), 32'h8);
    rd_exp(4'b1000, 32'h1);
    tick();
    rd_req = '0;

    // Two readers from rd_ptr 0: grants alternate 1,3,1.
    rd_req = 4'b1010;
    set_rd(1, 3'd2);
    set_rd(3, 3'd5);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (k == 1) begin
        chk("alt_rd_gnt", 32'(rd_gnt), 32'h8);
        rd_exp(4'b1000, 32'hDEADBEEF);
      end else begin
        chk("alt_rd_gnt", 32'(rd_gnt), 32'h2);
        rd_exp(4'b0010, 32'hA2);
      end
      tick();
    end
    rd_req = '0;

    // Grant to requester 2, then reset in the following cycle.
    rd_req = 4'b0100;
    set_rd(2, 3'd0);
    wr_req = 4'b0100;
    set_wr(2, 3'd7, 32'h55);
    #1;
    chk("pre_rst_rd_gnt", 32'(rd_gnt), 32'h4);
    chk("pre_rst_wr_gnt", 32'(wr_gnt), 32'h4);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    rd_req = '0;
    wr_req = '0;
    #1;
    chk("rst_clears_vld", 32'(rd_vld), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_rd(i, 3'd5);
    wr_req = 4'hF;
    rd_req = 4'hF;
    #1;
    chk("post_rst_wr_gnt", 32'(wr_gnt), 32'h1);
    chk("post_rst_rd_gnt", 32'(rd_gnt), 32'h1);
    rd_exp(4'b0001, 32'hDEADBEEF);
    tick();
    wr_req = '0;
    rd_req = '0;
    tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
